health_bar_gen: RTL and testbench
=================================

Name: health_bar_gen

Overview:
- Parametrised successor to the fixed 8-bit player health bar.
- Per-player health register with configurable width, maximum and damage amounts.
- Adds post-hit invulnerability frames, optional timed regeneration and a one-cycle damage-applied pulse.
- Sits between the fight/collision logic (hit/block levels) and the HUD renderer and game-over logic (health/death).

Parameters:
HP_WIDTH, 8, width of health value
HP_MAX, 250, reset/maximum health; must satisfy 0 < HP_MAX < 2**HP_WIDTH
HIT_DMG, 10, amount subtracted per accepted hit
BLOCK_DMG, 2, amount subtracted per accepted block
IFRAME_CYCLES, 16, invulnerable cycles after an accepted hit; 0 disables invulnerability
REGEN_PERIOD, 0, idle cycles between regen steps; 0 disables regen
REGEN_AMT, 1, amount added per regen step
CNT_WIDTH, 16, width of the iframe and regen counters; must hold IFRAME_CYCLES and REGEN_PERIOD

Ports:
Clk  input  1  system clock
Reset  input  1  asynchronous active-high reset
hit  input  1  level; attack landed on this player
block  input  1  level; attack landed while blocking
other_death  input  1  opponent is dead; freezes all health changes
health  output  HP_WIDTH  current health, registered
death  output  1  sticky; high once health reaches 0
invuln  output  1  high while in IFRAME
dmg_pulse  output  1  one-cycle pulse on the edge a damage decrement is applied

Behaviour:
- Interface: one clock, Clk. Reset is asynchronous and active-high.
- On Reset: state IDLE, health=HP_MAX, death=0, invuln=0, dmg_pulse=0, both counters 0.
- Reset mid-operation (any state, including DEAD or IFRAME) returns to these values immediately, with no clock required.
- States: IDLE, APPLY, HOLD, IFRAME, DEAD.
- IDLE:
  - If death or other_death is high, stay in IDLE and do nothing.
  - Else if hit is high, go to APPLY with src=HIT.
  - Else if block is high, go to APPLY with src=BLOCK.
  - hit has priority when hit and block are high together.
- APPLY (exactly one cycle):
  - On the exit edge, health <= health - dmg, where dmg is HIT_DMG or BLOCK_DMG.
  - If health <= dmg, health <= 0 and death <= 1 on the same edge.
  - dmg_pulse is registered, high for exactly the one cycle following the update edge.
  - Next state is DEAD if health reached 0, else HOLD.
- Latency: hit sampled high at edge k; APPLY occupies cycle k..k+1; health, death and dmg_pulse update at edge k+1.
- HOLD:
  - Wait until the triggering input (src) is low.
  - The other input is ignored while in HOLD.
  - Then go to IFRAME if src=HIT and IFRAME_CYCLES>0; otherwise go to IDLE.
  - Holding an input high therefore causes exactly one decrement.
- IFRAME:
  - Load the counter with IFRAME_CYCLES on entry; invuln=1.
  - hit and block are ignored.
  - The counter decrements each cycle; at 0, go to IDLE with invuln=0.
  - An input still high when IDLE is re-entered counts as a new event.
- DEAD: terminal until Reset. health stays 0, death stays 1, all inputs ignored.
- Regen (only when REGEN_PERIOD>0):
  - The counter runs only while state==IDLE, death==0, other_death==0 and health<HP_MAX.
  - Otherwise the counter clears to 0; it also clears on every APPLY.
  - When the counter reaches REGEN_PERIOD-1: health <= min(health+REGEN_AMT, HP_MAX), and the counter wraps to 0.
  - Regen and damage never coincide, because APPLY is not IDLE.
  - Compute the sum at HP_WIDTH+1 bits before saturating, so there is no wrap-around.
- Arithmetic: all compares and subtracts are unsigned at HP_WIDTH+1 bits. health never underflows and never exceeds HP_MAX.
- other_death rising in HOLD or IFRAME: those states complete normally, but IDLE accepts no further events.

Test Plan:
- Defaults; hit high for 1 cycle at edge k -> health 250->240 at edge k+1, dmg_pulse high 1 cycle, invuln high exactly 16 cycles after HOLD exits.
- Defaults; hit held high 100 cycles -> exactly one decrement (240), single dmg_pulse; IFRAME starts only after hit falls.
- Defaults; hit pulses while invuln=1 -> health unchanged; pulse after invuln falls -> 230.
- Defaults; block pulse -> 250->248, invuln stays 0; hit and block together -> 240 (hit wins).
- Defaults; 25 separated hits -> health 0 and death=1 on the same edge; further hits, blocks and other_death toggles leave health at 0; assert Reset mid-cycle -> health 250, death 0 asynchronously.
- REGEN_PERIOD=4, REGEN_AMT=3, HP_MAX=250; one hit (240), wait for IFRAME to end -> +3 every 4 idle cycles: 243, 246, 249, 250, then holds at 250; other_death=1 -> regen stops.

Source files
------------

// File: rtl/health_bar_gen.sv
// health_bar_gen: per-player health register with hit/block damage,
// post-hit invulnerability frames, optional timed regeneration,
// a sticky death flag and a one-cycle damage-applied pulse.
module health_bar_gen #(
   parameter int HP_WIDTH      = 8,
   parameter int HP_MAX        = 250,
   parameter int HIT_DMG       = 10,
   parameter int BLOCK_DMG     = 2,
   parameter int IFRAME_CYCLES = 16,
   parameter int REGEN_PERIOD  = 0,
   parameter int REGEN_AMT     = 1,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                hit,
   input  logic                block,
   input  logic                other_death,
   output logic [HP_WIDTH-1:0] health,
   output logic                death,
   output logic                invuln,
   output logic                dmg_pulse
);

   // All health arithmetic is done one bit wider so compares and sums never wrap.
   localparam logic [HP_WIDTH:0]    MAX_X       = (HP_WIDTH+1)'(HP_MAX);
   localparam logic [HP_WIDTH:0]    HIT_X       = (HP_WIDTH+1)'(HIT_DMG);
   localparam logic [HP_WIDTH:0]    BLOCK_X     = (HP_WIDTH+1)'(BLOCK_DMG);
   localparam logic [HP_WIDTH:0]    REGEN_AMT_X = (HP_WIDTH+1)'(REGEN_AMT);
   localparam logic [CNT_WIDTH-1:0] IFR_LOAD    = CNT_WIDTH'(IFRAME_CYCLES);
   localparam logic [CNT_WIDTH-1:0] REGEN_LAST  = CNT_WIDTH'(REGEN_PERIOD - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
   localparam bit                   REGEN_ON    = (REGEN_PERIOD > 0);
   localparam bit                   IFRAME_ON   = (IFRAME_CYCLES > 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_HOLD,
      S_IFRAME,
      S_DEAD
   } state_t;

   state_t                state_reg;
   logic                  src_hit_reg;     // 1: event came from hit, 0: from block
   logic [HP_WIDTH-1:0]   health_reg;
   logic                  death_reg;
   logic                  invuln_reg;
   logic                  dmg_pulse_reg;
   logic [CNT_WIDTH-1:0]  ifr_cnt_reg;
   logic [CNT_WIDTH-1:0]  regen_cnt_reg;

   logic [HP_WIDTH:0]     health_x;
   logic [HP_WIDTH:0]     dmg_x;
   logic [HP_WIDTH:0]     regen_sum;
   logic [HP_WIDTH-1:0]   regen_val;
   logic [CNT_WIDTH-1:0]  ifr_cnt_next;
   logic                  src_level;
   logic                  regen_run;
   logic                  regen_fire;

   // Damage selection, saturating regen sum and regen enable conditions.
   always_comb begin
      health_x     = {1'b0, health_reg};
      dmg_x        = src_hit_reg ? HIT_X : BLOCK_X;
      regen_sum    = health_x + REGEN_AMT_X;
      regen_val    = (regen_sum > MAX_X) ? MAX_X[HP_WIDTH-1:0] : regen_sum[HP_WIDTH-1:0];
      ifr_cnt_next = ifr_cnt_reg - CNT_ONE;
      src_level    = src_hit_reg ? hit : block;
      regen_run    = REGEN_ON && (state_reg == S_IDLE) && !death_reg &&
                     !other_death && (health_x < MAX_X);
      regen_fire   = regen_run && (regen_cnt_reg == REGEN_LAST);
   end

   // Health FSM with registered outputs and both counters.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_reg     <= S_IDLE;
         src_hit_reg   <= 1'b0;
         health_reg    <= MAX_X[HP_WIDTH-1:0];
         death_reg     <= 1'b0;
         invuln_reg    <= 1'b0;
         dmg_pulse_reg <= 1'b0;
         ifr_cnt_reg   <= '0;
         regen_cnt_reg <= '0;
      end else begin
         dmg_pulse_reg <= 1'b0;

         // Regen only advances in an idle, living, below-max state; otherwise it restarts.
         if (regen_run) begin
            if (regen_fire) begin
               health_reg    <= regen_val;
               regen_cnt_reg <= '0;
            end else begin
               regen_cnt_reg <= regen_cnt_reg + CNT_ONE;
            end
         end else begin
            regen_cnt_reg <= '0;
         end

         case (state_reg)
            S_IDLE: begin
               if (!death_reg && !other_death) begin
                  if (hit) begin
                     state_reg   <= S_APPLY;
                     src_hit_reg <= 1'b1;
                  end else if (block) begin
                     state_reg   <= S_APPLY;
                     src_hit_reg <= 1'b0;
                  end
               end
            end
            S_APPLY: begin
               dmg_pulse_reg <= 1'b1;
               if (health_x <= dmg_x) begin
                  health_reg <= '0;
                  death_reg  <= 1'b1;
                  state_reg  <= S_DEAD;
               end else begin
                  health_reg <= health_reg - dmg_x[HP_WIDTH-1:0];
                  state_reg  <= S_HOLD;
               end
            end
            S_HOLD: begin
               // A held input yields one decrement; wait for it to be released.
               if (!src_level) begin
                  if (src_hit_reg && IFRAME_ON) begin
                     state_reg   <= S_IFRAME;
                     ifr_cnt_reg <= IFR_LOAD;
                     invuln_reg  <= 1'b1;
                  end else begin
                     state_reg <= S_IDLE;
                  end
               end
            end
            S_IFRAME: begin
               ifr_cnt_reg <= ifr_cnt_next;
               if (ifr_cnt_next == '0) begin
                  state_reg  <= S_IDLE;
                  invuln_reg <= 1'b0;
               end
            end
            S_DEAD: begin
               state_reg <= S_DEAD;
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign health    = health_reg;
   assign death     = death_reg;
   assign invuln    = invuln_reg;
   assign dmg_pulse = dmg_pulse_reg;

endmodule

// File: tb/tb_health_bar_gen.sv
// Testbench for health_bar_gen: two instances (defaults, and regen enabled)
// driven with shared stimulus; expected outputs come from an event-level
// model and are checked by a monitor through per-instance scoreboards.
module tb_health_bar_gen;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       hit = 1'b0;
   logic       block = 1'b0;
   logic       other_death = 1'b0;
   logic [7:0] health0, health1;
   logic       death0, death1, invuln0, invuln1, pulse0, pulse1;

   int checks = 0;
   int failures = 0;

   always #5 Clk = ~Clk;

   health_bar_gen #(
      .HP_WIDTH(8), .HP_MAX(250), .HIT_DMG(10), .BLOCK_DMG(2),
      .IFRAME_CYCLES(16), .REGEN_PERIOD(0), .REGEN_AMT(1), .CNT_WIDTH(16)
   ) u_def (
      .Clk(Clk), .Reset(Reset), .hit(hit), .block(block), .other_death(other_death),
      .health(health0), .death(death0), .invuln(invuln0), .dmg_pulse(pulse0)
   );

   health_bar_gen #(
      .HP_WIDTH(8), .HP_MAX(250), .HIT_DMG(10), .BLOCK_DMG(2),
      .IFRAME_CYCLES(16), .REGEN_PERIOD(4), .REGEN_AMT(3), .CNT_WIDTH(16)
   ) u_regen (
      .Clk(Clk), .Reset(Reset), .hit(hit), .block(block), .other_death(other_death),
      .health(health1), .death(death1), .invuln(invuln1), .dmg_pulse(pulse1)
   );

   // Event-level player model: pending damage, waiting for release,
   // remaining invulnerable cycles and the idle-time regen accumulator.
   typedef struct {
      int hp;
      bit dead;
      bit pending;
      int src;          // 1 = hit, 2 = block
      bit wait_release;
      int inv_left;
      int acc;
      bit pulse;
      int hp_max, hit_dmg, block_dmg, ifr, rp, ra;
   } model_t;

   typedef struct {
      int hp;
      bit dead;
      bit inv;
      bit pulse;
   } exp_t;

   model_t m0, m1;
   exp_t   q0[$];
   exp_t   q1[$];

   function automatic model_t step(model_t m, bit h, bit b, bit od, bit r);
      int dmg;
      if (r) begin
         m.hp = m.hp_max; m.dead = 0; m.pending = 0; m.src = 0;
         m.wait_release = 0; m.inv_left = 0; m.acc = 0; m.pulse = 0;
         return m;
      end
      m.pulse = 0;
      if (m.dead) begin
         m.acc = 0;
      end else if (m.pending) begin
         dmg = (m.src == 1) ? m.hit_dmg : m.block_dmg;
         if (m.hp <= dmg) begin
            m.hp = 0;
            m.dead = 1;
         end else begin
            m.hp = m.hp - dmg;
            m.wait_release = 1;
         end
         m.pulse = 1;
         m.pending = 0;
         m.acc = 0;
      end else if (m.wait_release) begin
         m.acc = 0;
         if (!((m.src == 1) ? h : b)) begin
            m.wait_release = 0;
            if (m.src == 1 && m.ifr > 0) m.inv_left = m.ifr;
         end
      end else if (m.inv_left > 0) begin
         m.acc = 0;
         m.inv_left = m.inv_left - 1;
      end else begin
         if (m.rp > 0 && !od && m.hp < m.hp_max) begin
            if (m.acc == m.rp - 1) begin
               m.hp = (m.hp + m.ra > m.hp_max) ? m.hp_max : m.hp + m.ra;
               m.acc = 0;
            end else begin
               m.acc = m.acc + 1;
            end
         end else begin
            m.acc = 0;
         end
         if (!od) begin
            if (h) begin
               m.pending = 1; m.src = 1;
            end else if (b) begin
               m.pending = 1; m.src = 2;
            end
         end
      end
      return m;
   endfunction

   function automatic exp_t to_exp(model_t m);
      exp_t e;
      e.hp = m.hp; e.dead = m.dead; e.inv = (m.inv_left > 0); e.pulse = m.pulse;
      return e;
   endfunction

   task automatic chk(string name, int act, int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // One clock cycle of stimulus; the expected post-edge outputs are queued.
   task automatic cycle(bit h, bit b, bit o, bit r);
      @(negedge Clk);
      hit = h; block = b; other_death = o; Reset = r;
      m0 = step(m0, h, b, o, r);
      m1 = step(m1, h, b, o, r);
      q0.push_back(to_exp(m0));
      q1.push_back(to_exp(m1));
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Monitor: compare each instance against its scoreboard after every edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge Clk);
         #1;
         if (q0.size() > 0) begin
            e = q0.pop_front();
            checks++;
            if (int'(health0) != e.hp || death0 != e.dead || invuln0 != e.inv || pulse0 != e.pulse) begin
               failures++;
               $display("FAIL def_cycle t=%0t actual hp=%0d death=%0b inv=%0b pulse=%0b required hp=%0d death=%0b inv=%0b pulse=%0b",
                        $time, health0, death0, invuln0, pulse0, e.hp, e.dead, e.inv, e.pulse);
            end
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            checks++;
            if (int'(health1) != e.hp || death1 != e.dead || invuln1 != e.inv || pulse1 != e.pulse) begin
               failures++;
               $display("FAIL regen_cycle t=%0t actual hp=%0d death=%0b inv=%0b pulse=%0b required hp=%0d death=%0b inv=%0b pulse=%0b",
                        $time, health1, death1, invuln1, pulse1, e.hp, e.dead, e.inv, e.pulse);
            end
         end
      end
   end

   initial begin
      m0.hp_max = 250; m0.hit_dmg = 10; m0.block_dmg = 2; m0.ifr = 16; m0.rp = 0; m0.ra = 1;
      m1.hp_max = 250; m1.hit_dmg = 10; m1.block_dmg = 2; m1.ifr = 16; m1.rp = 4; m1.ra = 3;
      m0 = step(m0, 0, 0, 0, 1);
      m1 = step(m1, 0, 0, 0, 1);

      repeat (3) cycle(0, 0, 0, 1);
      chk("reset_hp", int'(health0), 250);
      chk("reset_death", int'(death0), 0);
      idle(2);

      // Single hit; regen instance climbs back to max afterwards.
      cycle(1, 0, 0, 0);
      idle(40);
      chk("single_hit_hp", int'(health0), 240);
      chk("regen_to_max", int'(health1), 250);

      // Hit held for 100 cycles gives one decrement.
      for (int i = 0; i < 100; i++) cycle(1, 0, 0, 0);
      idle(30);
      chk("held_hit_hp", int'(health0), 230);
      chk("held_hit_invuln", int'(invuln0), 0);

      // Hits during invulnerability are ignored.
      cycle(1, 0, 0, 0);
      idle(3);
      for (int i = 0; i < 6; i++) begin
         cycle(1, 0, 0, 0);
         cycle(0, 0, 0, 0);
      end
      idle(10);
      chk("iframe_ignores", int'(health0), 220);
      cycle(1, 0, 0, 0);
      idle(25);
      chk("hit_after_iframe", int'(health0), 210);

      // Block, then hit and block together.
      cycle(0, 1, 0, 0);
      idle(2);
      chk("block_no_invuln", int'(invuln0), 0);
      idle(3);
      chk("block_hp", int'(health0), 208);
      cycle(1, 1, 0, 0);
      idle(25);
      chk("hit_priority", int'(health0), 198);

      // other_death rises right after a hit: that hit completes, nothing else does.
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 40; i++) cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1, 0);
      idle(25);
      chk("other_death_freeze", int'(health0), 188);

      // Randomized traffic.
      for (int i = 0; i < 600; i++)
         cycle($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5, 0);
      idle(25);

      // Drive both players to death, then keep poking them.
      for (int i = 0; i < 30; i++) begin
         cycle(1, 0, 0, 0);
         idle(20);
      end
      chk("dead_hp", int'(health0), 0);
      chk("dead_flag", int'(death0), 1);
      chk("regen_dead_flag", int'(death1), 1);
      for (int i = 0; i < 30; i++)
         cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0);

      // Asynchronous reset in the middle of a cycle.
      @(negedge Clk);
      hit = 1'b0; block = 1'b0; other_death = 1'b0;
      #2;
      Reset = 1'b1;
      #1;
      chk("async_reset_hp", int'(health0), 250);
      chk("async_reset_death", int'(death0), 0);
      chk("async_reset_regen_hp", int'(health1), 250);
      m0 = step(m0, 0, 0, 0, 1);
      m1 = step(m1, 0, 0, 0, 1);
      q0.push_back(to_exp(m0));
      q1.push_back(to_exp(m1));
      repeat (2) cycle(0, 0, 0, 1);

      for (int i = 0; i < 200; i++)
         cycle($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 3, 0);
      idle(5);

      repeat (2) @(posedge Clk);
      #2;
      chk("scoreboard_drained", q0.size() + q1.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
